fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Write-side arbiter that shares the single write port of the 8-bit async FIFO among NUM_REQ requesters in the wrclk domain.
- Round-robin grant with bounded bursts.
- Drives the FIFO wrreq and data_in directly, and gates writes with the FIFO full flag so no word is lost or duplicated.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum words accepted per grant before rotation (1..255).
- DW, 8, data width; must equal FIFO data width.

Ports:
- wrclk  in  1  write-domain clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester "word available"; requester holds req and its data stable until acked.
- req_data  in  NUM_REQ*DW  packed data; requester i occupies bits [i*DW +: DW].
- full  in  1  FIFO full flag (write-domain, synchronised).
- gnt  out  NUM_REQ  registered one-hot owner of the write port; all zero when idle.
- ack  out  NUM_REQ  combinational; ack[i]=1 means req_data[i] is written this cycle.
- wrreq  out  1  combinational FIFO write strobe.
- data_in  out  DW  combinational mux of the owner's req_data; 0 when no owner.
- busy  out  1  registered; 1 while in BURST.

Behaviour:
- State machine has two states: IDLE and BURST.
- Registers:
  - state
  - owner index
  - rr_ptr: log2 NUM_REQ bits
  - burst_cnt: 8 bits
  - gnt, busy
- Reset (rst=1 at an edge), also applied mid-burst with no word flushing:
  - state=IDLE, gnt=0, busy=0, rr_ptr=0, burst_cnt=0.
  - wrreq=0 and ack=0 the following cycle.
- IDLE:
  - If any req is high, select the first requester at or after rr_ptr, searching upward with wrap from NUM_REQ-1 to 0.
  - Next cycle: state=BURST, gnt=onehot(owner), busy=1, burst_cnt=0.
  - Arbitration latency is 1 cycle from req to gnt.
  - No write occurs in IDLE.
- BURST write condition: wrreq = req[owner] & ~full.
  - ack[owner]=wrreq; all other ack bits are 0.
  - data_in = owner's req_data.
- On each accepted word, burst_cnt increments.
- Burst ends when either:
  - an accepted word makes burst_cnt reach MAX_BURST, or
  - req[owner]=0 at an edge (the requester is empty); this applies regardless of full.
- At burst end:
  - next state=IDLE, gnt=0, busy=0.
  - rr_ptr=(owner+1) mod NUM_REQ.
  - The end cycle's accepted word, if any, still counts as written.
- full=1 in BURST:
  - wrreq=0, ack=0, burst_cnt frozen.
  - Owner is retained indefinitely; there is no timeout and no rotation while stalled.
- Minimum gap between bursts is 1 IDLE cycle. A requester that keeps req high is re-granted only after every other active requester has had a turn.
- Single requester with continuous req: the pattern repeats as MAX_BURST writes then 1 idle cycle.
- Requests arriving in the same cycle as the selection edge are considered only by the next arbitration.
- req_data of non-owners is ignored.
- gnt is never multi-hot.
- wrreq is never 1 while full=1.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined:
  - Adds input cnt_sel (log2 NUM_REQ bits) and output cnt_out (16 bits).
  - Keeps one 16-bit saturating accepted-word counter per requester, incremented on ack[i].
  - Counters saturate at 16'hFFFF and clear on rst.
  - cnt_out is the registered value of counter[cnt_sel], 1-cycle read latency.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, req=0 -> gnt=0, busy=0, wrreq=0, data_in=0 for 5 cycles.
2. Single requester burst:
   - Stimulus: req=4'b0001, data 8'hA0..A7 advancing on ack, full=0.
   - Response: gnt=0001 one cycle after req; wrreq high 4 consecutive cycles writing A0..A3; 1 IDLE cycle; A4..A7 written in the next burst.
3. Round-robin rotation:
   - Stimulus: req=4'b1011 held, MAX_BURST=4.
   - Response: grant order 0,1,3,0; each owner writes exactly 4 words; requester 2 is never granted.
4. Full stall:
   - Stimulus: owner 1 mid-burst with burst_cnt=2; full=1 for 3 cycles.
   - Response: wrreq=0 and ack=0 during the stall; gnt stays 0010; after full drops, exactly 2 more words are written, then rotation.
5. Early drop and reset mid-burst:
   - Early drop: owner 2 drops req after 1 word -> IDLE next cycle, rr_ptr=3.
   - Reset mid-burst: rst pulsed mid-burst -> gnt=0 next cycle, rr_ptr=0, no write in the reset cycle's successor.
6. Stats (FIFO_WR_ARB_STATS_EN defined):
   - Stimulus: run scenario 3 for 3 full rotations, then cnt_sel=1.
   - Response: cnt_out=12 one cycle later; with cnt_sel=2, cnt_out=0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the single write port of an async FIFO among NUM_REQ
// requesters in the write clock domain. Round-robin grant with bursts bounded
// to MAX_BURST accepted words; writes are gated by the FIFO full flag so no
// word is lost or duplicated.
//
// Ports:
//   wrclk_i      write-domain clock
//   rst_i        synchronous active-high reset
//   req_i        per-requester word available (held with data until acked)
//   req_data_i   packed requester data, requester i at [i*DW +: DW]
//   full_i       FIFO full flag (already synchronised to wrclk)
//   gnt_o        registered one-hot owner, zero when idle
//   ack_o        combinational, ack_o[i] = word of requester i written this cycle
//   wrreq_o      combinational FIFO write strobe
//   data_in_o    combinational owner data, zero when no owner
//   busy_o       registered, high while a burst is in progress
//
// Optional (macro FIFO_WR_ARB_STATS_EN):
//   cnt_sel_i    selects a per-requester accepted-word counter
//   cnt_out_o    registered value of the selected 16-bit saturating counter
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned DW        = 8
) (
    input  logic                            wrclk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ*DW-1:0]           req_data_i,
    input  logic                            full_i,
`ifdef FIFO_WR_ARB_STATS_EN
    input  logic [$clog2(NUM_REQ)-1:0]      cnt_sel_i,
    output logic [15:0]                     cnt_out_o,
`endif
    output logic [NUM_REQ-1:0]              gnt_o,
    output logic [NUM_REQ-1:0]              ack_o,
    output logic                            wrreq_o,
    output logic [DW-1:0]                   data_in_o,
    output logic                            busy_o
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    typedef enum logic {StIdle, StBurst} state_e;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      owner_q, owner_d;
    logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [7:0]           burst_cnt_q, burst_cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 busy_q, busy_d;

    logic                 found;
    logic [IdxW-1:0]      sel_idx;
    int unsigned          cand;
    logic                 req_own;
    logic [IdxW-1:0]      owner_inc;

    // First requesting index at or after rr_ptr, wrapping at NUM_REQ-1.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        cand    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && req_i[cand[IdxW-1:0]]) begin
                found   = 1'b1;
                sel_idx = cand[IdxW-1:0];
            end
        end
    end

    assign req_own   = req_i[owner_q];
    assign owner_inc = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + IdxW'(1);

    // Write port: only the owner may write, and never while the FIFO is full.
    always_comb begin
        wrreq_o   = (state_q == StBurst) && req_own && !full_i;
        ack_o     = '0;
        data_in_o = '0;
        if (wrreq_o) begin
            ack_o[owner_q] = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if ((state_q == StBurst) && (owner_q == IdxW'(i))) begin
                data_in_o = req_data_i[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        gnt_d       = gnt_q;
        busy_d      = busy_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d     = StBurst;
                    owner_d     = sel_idx;
                    gnt_d       = NUM_REQ'(1) << sel_idx;
                    busy_d      = 1'b1;
                    burst_cnt_d = '0;
                end
            end
            StBurst: begin
                if (wrreq_o) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
                // An empty owner ends the burst even while stalled on full.
                if ((wrreq_o && (burst_cnt_q == 8'(MAX_BURST - 1))) || !req_own) begin
                    state_d  = StIdle;
                    gnt_d    = '0;
                    busy_d   = 1'b0;
                    rr_ptr_d = owner_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wrclk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign busy_o = busy_q;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] stat_q;
    logic [15:0]              cnt_out_q;

    always_ff @(posedge wrclk_i) begin
        if (rst_i) begin
            stat_q    <= '0;
            cnt_out_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (ack_o[i] && (stat_q[i] != 16'hFFFF)) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end
            end
            cnt_out_q <= stat_q[cnt_sel_i];
        end
    end

    assign cnt_out_o = cnt_out_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_fifo_wr_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 4;
    localparam int DW   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              full;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      gnt, ack;
    logic              wrreq, busy;
    logic [DW-1:0]     data_in;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [1:0]        cnt_sel;
    logic [15:0]       cnt_out;
`endif

    // Requester models: en = wants to send, rem = words left, nxt = current word.
    bit                en[N];
    int unsigned       rem[N];
    logic [DW-1:0]     nxt[N];

    always_comb begin
        req      = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req[i]               = en[i] && (rem[i] != 0);
            req_data[i*DW +: DW] = nxt[i];
        end
    end

    fifo_wr_arbiter #(.NUM_REQ(N), .MAX_BURST(MAXB), .DW(DW)) dut (
        .wrclk_i    (clk),
        .rst_i      (rst),
        .req_i      (req),
        .req_data_i (req_data),
        .full_i     (full),
`ifdef FIFO_WR_ARB_STATS_EN
        .cnt_sel_i  (cnt_sel),
        .cnt_out_o  (cnt_out),
`endif
        .gnt_o      (gnt),
        .ack_o      (ack),
        .wrreq_o    (wrreq),
        .data_in_o  (data_in),
        .busy_o     (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: owner is -1 when nobody holds the port.
    int            m_owner = -1;
    int            m_ptr   = 0;
    int            m_cnt   = 0;
    int            m_stat[N];
    logic [N-1:0]  exp_gnt, exp_ack;
    logic          exp_busy, exp_wr;
    logic [DW-1:0] exp_data;

    function automatic void model_eval();
        exp_gnt  = '0;
        exp_ack  = '0;
        exp_busy = 1'b0;
        exp_wr   = 1'b0;
        exp_data = '0;
        if (m_owner >= 0) begin
            exp_gnt[m_owner] = 1'b1;
            exp_busy         = 1'b1;
            exp_wr           = req[m_owner] && !full;
            exp_ack[m_owner] = exp_wr;
            exp_data         = nxt[m_owner];
        end
    endfunction

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    // Apply one clock edge to the model, the DUT and the requesters.
    task automatic advance();
        int w;
        w = exp_wr ? m_owner : -1;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
            for (int i = 0; i < N; i++) m_stat[i] = 0;
        end else begin
            if (w >= 0 && m_stat[w] < 65535) m_stat[w]++;
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                end
                m_cnt = 0;
            end else begin
                if (exp_wr) m_cnt++;
                if ((exp_wr && m_cnt == MAXB) || !req[m_owner]) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (w >= 0) begin
            nxt[w] = nxt[w] + 8'd1;
            rem[w] = rem[w] - 1;
        end
    endtask

    task automatic do_reset(input int cycles);
        full = 1'b0;
        for (int i = 0; i < N; i++) begin
            en[i]  = 1'b0;
            rem[i] = 0;
        end
        rst = 1'b1;
        repeat (cycles) begin
            settle();
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        repeat (5) begin
            settle();
            vectors++;
            if ({gnt, busy, wrreq, ack, data_in} !== '0) begin
                miscompares++;
                $display("FAIL reset_idle: gnt=%b busy=%b wrreq=%b ack=%b data=%h, required all 0",
                         gnt, busy, wrreq, ack, data_in);
            end
            advance();
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] got[$];
        do_reset(1);
        en[0]  = 1'b1;
        rem[0] = 8;
        nxt[0] = 8'hA0;
        repeat (14) begin
            settle();
            vectors++;
            if ({gnt, busy, wrreq, ack, data_in} !== {exp_gnt, exp_busy, exp_wr, exp_ack, exp_data}) begin
                miscompares++;
                $display("FAIL single: gnt/busy/wr/ack/data=%b/%b/%b/%b/%h required %b/%b/%b/%b/%h",
                         gnt, busy, wrreq, ack, data_in,
                         exp_gnt, exp_busy, exp_wr, exp_ack, exp_data);
            end
            if (wrreq === 1'b1) got.push_back(data_in);
            advance();
        end
        vectors++;
        if (got.size() != 8) begin
            miscompares++;
            $display("FAIL single_count: wrote %0d words, required 8", got.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                vectors++;
                if (got[k] !== 8'(8'hA0 + k)) begin
                    miscompares++;
                    $display("FAIL single_data[%0d]: got %h required %h", k, got[k], 8'(8'hA0 + k));
                end
            end
        end
        en[0] = 1'b0;
    endtask

    task automatic test_round_robin();
        int           order[$];
        int           counts[$];
        int           exp_order[4] = '{0, 1, 3, 0};
        logic [N-1:0] prev_gnt;
        int           nwr;
        do_reset(1);
        for (int i = 0; i < N; i++) begin
            en[i]  = (i != 2);
            rem[i] = 100;
            nxt[i] = 8'($urandom);
        end
        prev_gnt = '0;
        nwr      = 0;
        repeat (22) begin
            settle();
            vectors++;
            if ({gnt, busy, wrreq, ack, data_in} !== {exp_gnt, exp_busy, exp_wr, exp_ack, exp_data}) begin
                miscompares++;
                $display("FAIL round_robin: gnt/busy/wr/ack/data=%b/%b/%b/%b/%h required %b/%b/%b/%b/%h",
                         gnt, busy, wrreq, ack, data_in,
                         exp_gnt, exp_busy, exp_wr, exp_ack, exp_data);
            end
            if (gnt !== '0 && prev_gnt === '0) begin
                for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
                nwr = 0;
            end
            if (gnt === '0 && prev_gnt !== '0) counts.push_back(nwr);
            if (wrreq === 1'b1) nwr++;
            prev_gnt = gnt;
            advance();
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (k >= order.size() || order[k] != exp_order[k]) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: got %0d required %0d", k,
                         (k < order.size()) ? order[k] : -1, exp_order[k]);
            end
            vectors++;
            if (k >= counts.size() || counts[k] != MAXB) begin
                miscompares++;
                $display("FAIL rr_burst_len[%0d]: got %0d required %0d", k,
                         (k < counts.size()) ? counts[k] : -1, MAXB);
            end
        end
    endtask

    task automatic test_full_stall();
        int guard;
        int post;
        do_reset(1);
        en[1]  = 1'b1;
        rem[1] = 100;
        nxt[1] = 8'h10;
        guard  = 0;
        while (!(m_owner == 1 && m_cnt == 2) && guard < 20) begin
            settle();
            advance();
            guard++;
        end
        vectors++;
        if (guard >= 20) begin
            miscompares++;
            $display("FAIL stall_setup: owner 1 never reached 2 words, got owner %0d count %0d",
                     m_owner, m_cnt);
        end
        full = 1'b1;
        repeat (3) begin
            settle();
            vectors++;
            if ({gnt, wrreq, ack} !== {4'b0010, 1'b0, 4'b0000}) begin
                miscompares++;
                $display("FAIL stall_hold: gnt=%b wrreq=%b ack=%b required 0010/0/0000",
                         gnt, wrreq, ack);
            end
            advance();
        end
        full  = 1'b0;
        en[2] = 1'b1;
        rem[2] = 5;
        post  = 0;
        repeat (10) begin
            settle();
            vectors++;
            if ({gnt, busy, wrreq, ack, data_in} !== {exp_gnt, exp_busy, exp_wr, exp_ack, exp_data}) begin
                miscompares++;
                $display("FAIL stall_resume: gnt/busy/wr/ack/data=%b/%b/%b/%b/%h required %b/%b/%b/%b/%h",
                         gnt, busy, wrreq, ack, data_in,
                         exp_gnt, exp_busy, exp_wr, exp_ack, exp_data);
            end
            if (ack[1] === 1'b1 && post >= 0) post++;
            if (gnt === 4'b0100) post = (post >= 0) ? -post - 100 : post;
            advance();
        end
        // post is encoded as -(words)-100 once owner 2 took over.
        vectors++;
        if (post != -102) begin
            miscompares++;
            $display("FAIL stall_post_words: code %0d, required -102 (2 words then rotation to 2)",
                     post);
        end
    endtask

    task automatic test_early_drop_reset();
        do_reset(1);
        en[2]  = 1'b1;
        rem[2] = 1;
        nxt[2] = 8'h55;
        repeat (3) begin
            settle();
            vectors++;
            if ({gnt, busy, wrreq, ack, data_in} !== {exp_gnt, exp_busy, exp_wr, exp_ack, exp_data}) begin
                miscompares++;
                $display("FAIL early_drop: gnt/busy/wr/ack/data=%b/%b/%b/%b/%h required %b/%b/%b/%b/%h",
                         gnt, busy, wrreq, ack, data_in,
                         exp_gnt, exp_busy, exp_wr, exp_ack, exp_data);
            end
            advance();
        end
        en[0]  = 1'b1;
        rem[0] = 50;
        en[3]  = 1'b1;
        rem[3] = 50;
        settle();
        vectors++;
        if ({gnt, busy, wrreq} !== 6'b0) begin
            miscompares++;
            $display("FAIL early_drop_idle: gnt=%b busy=%b wrreq=%b required idle", gnt, busy, wrreq);
        end
        advance();
        settle();
        vectors++;
        if (gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL early_drop_next_owner: gnt=%b required 1000", gnt);
        end
        advance();
        rst = 1'b1;
        settle();
        advance();
        rst = 1'b0;
        settle();
        vectors++;
        if ({gnt, busy, wrreq, ack} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_burst: gnt=%b busy=%b wrreq=%b ack=%b required all 0",
                     gnt, busy, wrreq, ack);
        end
        advance();
        settle();
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_ptr: gnt=%b required 0001", gnt);
        end
        advance();
    endtask

    task automatic test_random();
        do_reset(1);
        repeat (500) begin
            rst  = ($urandom_range(0, 59) == 0);
            full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 24) == 0) en[i] = !en[i];
                if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
                    rem[i] = $urandom_range(1, 10);
                    nxt[i] = 8'($urandom);
                end
            end
            settle();
            vectors++;
            if ({gnt, busy, wrreq, ack, data_in} !== {exp_gnt, exp_busy, exp_wr, exp_ack, exp_data}) begin
                miscompares++;
                $display("FAIL random: gnt/busy/wr/ack/data=%b/%b/%b/%b/%h required %b/%b/%b/%b/%h",
                         gnt, busy, wrreq, ack, data_in,
                         exp_gnt, exp_busy, exp_wr, exp_ack, exp_data);
            end
            vectors++;
            if ($countones(gnt) > 1 || (wrreq === 1'b1 && full)) begin
                miscompares++;
                $display("FAIL random_safety: gnt=%b wrreq=%b full=%b", gnt, wrreq, full);
            end
            advance();
        end
        rst = 1'b0;
    endtask

`ifdef FIFO_WR_ARB_STATS_EN
    task automatic test_stats();
        do_reset(1);
        for (int i = 0; i < N; i++) begin
            en[i]  = (i != 2);
            rem[i] = (i != 2) ? 12 : 0;
        end
        repeat (70) begin
            settle();
            vectors++;
            if ({gnt, busy, wrreq, ack, data_in} !== {exp_gnt, exp_busy, exp_wr, exp_ack, exp_data}) begin
                miscompares++;
                $display("FAIL stats_traffic: gnt/busy/wr/ack/data=%b/%b/%b/%b/%h required %b/%b/%b/%b/%h",
                         gnt, busy, wrreq, ack, data_in,
                         exp_gnt, exp_busy, exp_wr, exp_ack, exp_data);
            end
            advance();
        end
        for (int s = 1; s <= 2; s++) begin
            cnt_sel = 2'(s);
            settle();
            advance();
            settle();
            vectors++;
            if (cnt_out !== 16'(m_stat[s]) || cnt_out !== ((s == 1) ? 16'd12 : 16'd0)) begin
                miscompares++;
                $display("FAIL stats_cnt[%0d]: got %0d required %0d", s, cnt_out, m_stat[s]);
            end
            advance();
        end
    endtask
`endif

    initial begin
        rst  = 1'b1;
        full = 1'b0;
        for (int i = 0; i < N; i++) begin
            en[i]     = 1'b0;
            rem[i]    = 0;
            nxt[i]    = '0;
            m_stat[i] = 0;
        end
`ifdef FIFO_WR_ARB_STATS_EN
        cnt_sel = '0;
`endif
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_early_drop_reset();
        test_random();
`ifdef FIFO_WR_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
